arb_req_ctrl: RTL and testbench

- Two-channel request front-end sitting directly upstream of the 2-requester arbiter; drives its request[1:0] and consumes its grant[1:0].
- Queues jobs per channel, raises request while jobs are pending, and holds request for a fixed burst once granted.
- Drops request for at least one cycle after each burst so the arbiter can rotate.
- Flags starvation and illegal grant patterns for the test layer.

---
 rtl/arb_req_ctrl.sv | 144 ++++++++++++++
 tb/tb_arb_req_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_ctrl.sv
// Two-channel request front-end for a 2-requester arbiter: queues jobs per channel,
// holds request through a fixed-length burst, and flags starvation and illegal grants.
module arb_req_ctrl #(
    parameter int PEND_W    = 4,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        job_valid,
    output logic [1:0]        job_ready,
    output logic [1:0]        request,
    input  logic [1:0]        grant,
    output logic [1:0]        done,
    output logic [PEND_W-1:0] pending0,
    output logic [PEND_W-1:0] pending1,
    output logic [1:0]        starve,
    output logic              gnt_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [PEND_W-1:0] PEND_FULL = {PEND_W{1'b1}};

    logic                   gnt_bad_s;
    logic [1:0][PEND_W-1:0] pend_s;
    logic                   gnt_err_q;

    // An illegal both-granted pattern freezes both channel FSMs for that edge.
    assign gnt_bad_s = (grant == 2'b11);

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [1:0]        state_q, state_d;
        logic [BEAT_W-1:0] beat_q, beat_d;
        logic [WAIT_W-1:0] wait_q, wait_d;
        logic [PEND_W-1:0] pend_q, pend_d;
        logic              req_q, done_q, done_d, starve_q, starve_d;
        logic              accept_s;

        assign job_ready[ch] = (pend_q != PEND_FULL);
        assign accept_s      = job_valid[ch] & job_ready[ch];

        // Next-state, beat/wait counters, job counter and sticky starvation flag.
        always_comb begin
            state_d  = state_q;
            beat_d   = beat_q;
            wait_d   = wait_q;
            done_d   = 1'b0;
            if (gnt_bad_s) begin
                state_d = state_q;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pend_q != {PEND_W{1'b0}}) begin
                            state_d = ST_REQ;
                            wait_d  = {WAIT_W{1'b0}};
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_REQ: begin
                        if (grant[ch]) begin
                            state_d = ST_XFER;
                            beat_d  = {BEAT_W{1'b0}};
                        end else if (wait_q != WAIT_MAX) begin
                            wait_d = wait_q + 1'b1;
                        end else begin
                            wait_d = wait_q;
                        end
                    end
                    ST_XFER: begin
                        if (!grant[ch]) begin
                            state_d = ST_REQ;
                            beat_d  = {BEAT_W{1'b0}};
                        end else if (beat_q == BEAT_LAST) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            case ({accept_s, done_d})
                2'b10:   pend_d = pend_q + 1'b1;
                2'b01:   pend_d = pend_q - 1'b1;
                default: pend_d = pend_q;
            endcase

            starve_d = starve_q | (wait_d == WAIT_MAX);
        end

        // Channel state registers; request is decoded from the next state so it is registered.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q  <= ST_IDLE;
                beat_q   <= {BEAT_W{1'b0}};
                wait_q   <= {WAIT_W{1'b0}};
                pend_q   <= {PEND_W{1'b0}};
                req_q    <= 1'b0;
                done_q   <= 1'b0;
                starve_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                beat_q   <= beat_d;
                wait_q   <= wait_d;
                pend_q   <= pend_d;
                req_q    <= (state_d == ST_REQ) || (state_d == ST_XFER);
                done_q   <= done_d;
                starve_q <= starve_d;
            end
        end

        assign request[ch] = req_q;
        assign done[ch]    = done_q;
        assign starve[ch]  = starve_q;
        assign pend_s[ch]  = pend_q;
    end

    // Sticky record of any both-granted edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_err_q <= 1'b0;
        end else begin
            gnt_err_q <= gnt_err_q | gnt_bad_s;
        end
    end

    assign gnt_err  = gnt_err_q;
    assign pending0 = pend_s[0];
    assign pending1 = pend_s[1];

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Self-checking bench for arb_req_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a job-level behavioural model.
module tb_arb_req_ctrl;

    localparam int PEND_W    = 4;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 16;
    localparam int MAXP      = (1 << PEND_W) - 1;

    logic              clk;
    logic              rst;
    logic [1:0]        job_valid;
    logic [1:0]        job_ready;
    logic [1:0]        request;
    logic [1:0]        grant;
    logic [1:0]        done;
    logic [PEND_W-1:0] pending0;
    logic [PEND_W-1:0] pending1;
    logic [1:0]        starve;
    logic              gnt_err;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = idle, 1 = waiting for grant, 2 = in burst.
    int m_pend [2];
    int m_phase[2];
    int m_beat [2];
    int m_wait [2];
    bit m_starve[2];
    bit m_done [2];
    bit m_gerr;

    arb_req_ctrl #(.PEND_W(PEND_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .request(request), .grant(grant), .done(done), .pending0(pending0),
        .pending1(pending1), .starve(starve), .gnt_err(gnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge(input logic [1:0] jv, input logic [1:0] g, input logic r);
        if (r) begin
            for (int c = 0; c < 2; c++) begin
                m_pend[c] = 0; m_phase[c] = 0; m_beat[c] = 0; m_wait[c] = 0;
                m_starve[c] = 1'b0; m_done[c] = 1'b0;
            end
            m_gerr = 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                int fin;
                fin = 0;
                if (g != 2'b11) begin
                    case (m_phase[c])
                        0: if (m_pend[c] > 0) begin m_phase[c] = 1; m_wait[c] = 0; end
                        1: if (g[c]) begin m_phase[c] = 2; m_beat[c] = 0; end
                           else if (m_wait[c] < TIMEOUT) m_wait[c]++;
                        2: if (!g[c]) begin m_phase[c] = 1; m_beat[c] = 0; end
                           else if (m_beat[c] == BURST_LEN - 1) begin m_phase[c] = 0; fin = 1; end
                           else m_beat[c]++;
                        default: m_phase[c] = 0;
                    endcase
                end
                m_done[c] = (fin != 0);
                if (jv[c] && m_pend[c] < MAXP) m_pend[c]++;
                m_pend[c] -= fin;
                if (m_wait[c] >= TIMEOUT) m_starve[c] = 1'b1;
            end
            if (g == 2'b11) m_gerr = 1'b1;
        end
    endtask

    function automatic logic [16:0] exp_vec();
        logic [1:0] rq, dn, rd, sv;
        for (int c = 0; c < 2; c++) begin
            rq[c] = (m_phase[c] != 0);
            dn[c] = m_done[c];
            rd[c] = (m_pend[c] != MAXP);
            sv[c] = m_starve[c];
        end
        return {rq, dn, PEND_W'(m_pend[0]), PEND_W'(m_pend[1]), rd, sv, m_gerr};
    endfunction

    function automatic logic [1:0] m_req();
        return {m_phase[1] != 0, m_phase[0] != 0};
    endfunction

    task automatic step(input logic [1:0] jv, input logic [1:0] g, input logic r);
        @(negedge clk);
        job_valid = jv;
        grant     = g;
        rst       = r;
        @(posedge clk);
        model_edge(jv, g, r);
        #1;
    endtask

    task automatic test_reset();
        step(2'b11, 2'b00, 1'b1);
        step(2'b11, 2'b00, 1'b1);
        checks++;
        if ({request, pending0, pending1, job_ready, starve, gnt_err, done} !== {2'b00, 4'd0, 4'd0, 2'b11, 2'b00, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset: req=%b p0=%0d p1=%0d rdy=%b stv=%b gerr=%b done=%b, want 0/0/0/11/00/0/00",
                     request, pending0, pending1, job_ready, starve, gnt_err, done);
        end
        step(2'b00, 2'b00, 1'b0);
        checks++;
        if ({request, pending0, pending1} !== {2'b00, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_idle: req=%b p0=%0d p1=%0d, want 00/0/0", request, pending0, pending1);
        end
    endtask

    task automatic test_single();
        step(2'b00, 2'b00, 1'b1);
        step(2'b01, 2'b00, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            step(2'b00, {1'b0, m_req()[0]}, 1'b0);
            checks++;
            if (request[0] !== (k >= 1 && k <= 5) || done[0] !== (k == 6)) begin
                errors++;
                $display("FAIL single cycle %0d: req0=%b done0=%b, want %b/%b",
                         k, request[0], done[0], (k >= 1 && k <= 5), (k == 6));
            end
        end
        checks++;
        if (pending0 !== 4'd0) begin
            errors++;
            $display("FAIL single_pend: pending0=%0d want 0", pending0);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        bit prev_done;
        dones = 0;
        prev_done = 1'b0;
        step(2'b00, 2'b00, 1'b1);
        for (int k = 0; k < 3; k++) step(2'b10, {m_req()[1], 1'b0}, 1'b0);
        checks++;
        if (pending1 !== 4'd3) begin
            errors++;
            $display("FAIL b2b_pend3: pending1=%0d want 3", pending1);
        end
        for (int k = 0; k < 60 && dones < 3; k++) begin
            step(2'b00, {m_req()[1], 1'b0}, 1'b0);
            if (prev_done) begin
                checks++;
                if (request[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_rerise: req1=%b want 1 one cycle after done", request[1]);
                end
            end
            prev_done = 1'b0;
            if (done[1] === 1'b1) begin
                dones++;
                prev_done = (dones < 3);
                checks++;
                if (request[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gap: req1=%b want 0 in done cycle", request[1]);
                end
            end
        end
        checks++;
        if (dones != 3 || pending1 !== 4'd0) begin
            errors++;
            $display("FAIL b2b_total: dones=%0d pending1=%0d, want 3/0", dones, pending1);
        end
    endtask

    task automatic test_full();
        int comps;
        logic [1:0] jv;
        comps = 0;
        step(2'b00, 2'b00, 1'b1);
        for (int k = 0; k < 16; k++) step(2'b01, 2'b00, 1'b0);
        checks++;
        if (pending0 !== 4'd15 || job_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL full: pending0=%0d rdy0=%b, want 15/0", pending0, job_ready[0]);
        end
        step(2'b01, 2'b00, 1'b0);
        checks++;
        if (pending0 !== 4'd15) begin
            errors++;
            $display("FAIL full_drop: pending0=%0d want 15", pending0);
        end
        for (int k = 0; k < 40 && comps < 2; k++) begin
            jv = (comps == 1 && m_phase[0] == 2 && m_beat[0] == BURST_LEN - 1) ? 2'b01 : 2'b00;
            step(jv, 2'b01, 1'b0);
            if (done[0] === 1'b1) begin
                comps++;
                checks++;
                if (pending0 !== 4'd14) begin
                    errors++;
                    $display("FAIL full_completion %0d: pending0=%0d want 14", comps, pending0);
                end
            end
        end
        checks++;
        if (comps != 2) begin
            errors++;
            $display("FAIL full_timeout: completions=%0d want 2", comps);
        end
    endtask

    task automatic test_starve_preempt();
        step(2'b00, 2'b00, 1'b1);
        step(2'b01, 2'b00, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            step(2'b00, 2'b00, 1'b0);
            if (k >= 16) begin
                checks++;
                if (starve[0] !== (k == 17)) begin
                    errors++;
                    $display("FAIL starve edge %0d: starve0=%b want %b", k, starve[0], (k == 17));
                end
            end
        end
        for (int k = 0; k < 3; k++) step(2'b00, 2'b01, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        checks++;
        if ({request[0], done[0], pending0, starve[0]} !== {1'b1, 1'b0, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL preempt: req0=%b done0=%b p0=%0d stv0=%b, want 1/0/1/1",
                     request[0], done[0], pending0, starve[0]);
        end
        step(2'b00, 2'b01, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(2'b00, 2'b01, 1'b0);
            checks++;
            if (done[0] !== (k == 4)) begin
                errors++;
                $display("FAIL regrant beat %0d: done0=%b want %b", k, done[0], (k == 4));
            end
        end
        checks++;
        if (pending0 !== 4'd0 || starve[0] !== 1'b1) begin
            errors++;
            $display("FAIL regrant_end: p0=%0d stv0=%b, want 0/1", pending0, starve[0]);
        end
    endtask

    task automatic test_illegal_reset();
        step(2'b00, 2'b00, 1'b1);
        step(2'b11, 2'b00, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b11, 1'b0);
        checks++;
        if ({gnt_err, request, done} !== {1'b1, 2'b11, 2'b00}) begin
            errors++;
            $display("FAIL illegal: gerr=%b req=%b done=%b, want 1/11/00", gnt_err, request, done);
        end
        step(2'b00, 2'b01, 1'b0);
        step(2'b00, 2'b11, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(2'b00, 2'b01, 1'b0);
            checks++;
            if (done[0] !== (k == 4) || gnt_err !== 1'b1) begin
                errors++;
                $display("FAIL freeze beat %0d: done0=%b gerr=%b, want %b/1", k, done[0], gnt_err, (k == 4));
            end
        end
        step(2'b01, 2'b00, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b01, 1'b0);
        step(2'b00, 2'b01, 1'b0);
        step(2'b00, 2'b01, 1'b1);
        checks++;
        if ({done, pending0, pending1, gnt_err, request} !== {2'b00, 4'd0, 4'd0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL midburst_reset: done=%b p0=%0d p1=%0d gerr=%b req=%b, want 00/0/0/0/00",
                     done, pending0, pending1, gnt_err, request);
        end
        step(2'b00, 2'b01, 1'b0);
        checks++;
        if (done !== 2'b00) begin
            errors++;
            $display("FAIL midburst_nodone: done=%b want 00", done);
        end
    endtask

    task automatic test_random();
        logic [1:0] jv, g;
        logic       r;
        logic [16:0] exp_s;
        step(2'b00, 2'b00, 1'b1);
        for (int k = 0; k < 1500; k++) begin
            jv = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) g = m_req() & 2'($urandom_range(1, 2));
            else                          g = 2'($urandom_range(0, 3));
            r = ($urandom_range(0, 299) == 0);
            step(jv, g, r);
            exp_s = exp_vec();
            checks++;
            if ({request, done, pending0, pending1, job_ready, starve, gnt_err} !== exp_s) begin
                errors++;
                $display("FAIL random cycle %0d: got %b want %b (req,done,p0,p1,rdy,stv,gerr)",
                         k, {request, done, pending0, pending1, job_ready, starve, gnt_err}, exp_s);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        job_valid = 2'b00;
        grant     = 2'b00;
        model_edge(2'b00, 2'b00, 1'b1);
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_starve_preempt();
        test_illegal_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
